reg_port_arbiter: RTL and testbench

Controller for the single-port 16x8 register file. It sits between the register file's single `reg_in`/`data_in`/`write_ctrl` port and two requesters:

- **A:** execute stage.
- **B:** debug/loader port.

After every reset it zero-initialises all 16 registers, because the register file itself has no reset. It then arbitrates one access per cycle, round-robin, with an optional lock for read-modify-write sequences.

---
 rtl/reg_port_arbiter_if.sv | 25 ++
 rtl/reg_port_arbiter.sv | 130 +++++++++++++
 tb/tb_reg_port_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_port_arbiter_if.sv
// Request/response bundle for one requester of the register-file arbiter.
// The requester owns the master side; the arbiter owns the slave side.
interface reg_port_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Single-port register-file controller: clears every register after reset,
// then serves requesters A and B round-robin with an optional priority lock.
module reg_port_arbiter #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    reg_port_arbiter_if.slave a_port,
    reg_port_arbiter_if.slave b_port,
    output logic [ADDR_W-1:0] rf_reg_in,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write_ctrl,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              clear_busy
);
    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pri_q, pri_d;

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]        req_w, we_w, lock_w, gnt_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic              rvalid_q [2];

    assign req_w   = {b_port.req,  a_port.req};
    assign we_w    = {b_port.we,   a_port.we};
    assign lock_w  = {b_port.lock, a_port.lock};
    assign addr_w[0]  = a_port.addr;
    assign addr_w[1]  = b_port.addr;
    assign wdata_w[0] = a_port.wdata;
    assign wdata_w[1] = b_port.wdata;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pri_q   <= pri_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pri_d   = pri_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_SERVE;
                end
            end
            default: begin
                // A locked grant keeps priority; any other grant hands it over.
                if (gnt_w[0]) begin
                    pri_d = ~lock_w[0];
                end else if (gnt_w[1]) begin
                    pri_d = lock_w[1];
                end
            end
        endcase
    end

    always_comb begin
        gnt_w         = 2'b00;
        rf_reg_in     = '0;
        rf_data_in    = '0;
        rf_write_ctrl = 1'b0;
        clear_busy    = 1'b0;
        if (RESET) begin
            clear_busy = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            clear_busy    = 1'b1;
            rf_reg_in     = cnt_q;
            rf_write_ctrl = 1'b1;
        end else begin
            gnt_w[0] = req_w[0] & (~req_w[1] | ~pri_q);
            gnt_w[1] = req_w[1] & (~req_w[0] |  pri_q);
            if (gnt_w[0]) begin
                rf_reg_in     = addr_w[0];
                rf_data_in    = wdata_w[0];
                rf_write_ctrl = we_w[0];
            end else if (gnt_w[1]) begin
                rf_reg_in     = addr_w[1];
                rf_data_in    = wdata_w[1];
                rf_write_ctrl = we_w[1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic              rvalid_d;
            logic [DATA_W-1:0] rdata_d;

            always_comb begin
                rvalid_d = gnt_w[gi] & ~we_w[gi];
                rdata_d  = rvalid_d ? rf_data_out : rdata_q[gi];
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    rvalid_q[gi] <= 1'b0;
                    rdata_q[gi]  <= '0;
                end else begin
                    rvalid_q[gi] <= rvalid_d;
                    rdata_q[gi]  <= rdata_d;
                end
            end
        end
    endgenerate

    assign a_port.gnt    = gnt_w[0];
    assign b_port.gnt    = gnt_w[1];
    assign a_port.rdata  = rdata_q[0];
    assign b_port.rdata  = rdata_q[1];
    assign a_port.rvalid = rvalid_q[0];
    assign b_port.rvalid = rvalid_q[1];
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a behavioural 16x8 register file.
module tb_reg_port_arbiter;
    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] rf_reg_in;
    logic [7:0] rf_data_in;
    logic       rf_write_ctrl;
    logic [7:0] rf_data_out;
    logic       clear_busy;
    logic       preload;
    logic [7:0] rf_mem [16];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 CLK = ~CLK;

    reg_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) a_if ();
    reg_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) b_if ();

    reg_port_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(8)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .a_port        (a_if),
        .b_port        (b_if),
        .rf_reg_in     (rf_reg_in),
        .rf_data_in    (rf_data_in),
        .rf_write_ctrl (rf_write_ctrl),
        .rf_data_out   (rf_data_out),
        .clear_busy    (clear_busy)
    );

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'hFF;
        end else if (rf_write_ctrl) begin
            rf_mem[rf_reg_in] <= rf_data_in;
        end
    end
    assign rf_data_out = rf_mem[rf_reg_in];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv_a(input logic req, input logic we, input logic [3:0] addr,
                         input logic [7:0] wdata, input logic lock);
        a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.lock = lock;
    endtask

    task automatic drv_b(input logic req, input logic we, input logic [3:0] addr,
                         input logic [7:0] wdata, input logic lock);
        b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.lock = lock;
    endtask

    initial begin
        RESET = 1'b1;
        preload = 1'b1;
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        check_val("rst_agnt", a_if.gnt, 0);
        check_val("rst_bgnt", b_if.gnt, 0);
        check_val("rst_arvalid", a_if.rvalid, 0);
        check_val("rst_brvalid", b_if.rvalid, 0);
        check_val("rst_ardata", a_if.rdata, 0);
        check_val("rst_brdata", b_if.rdata, 0);
        check_val("rst_we", rf_write_ctrl, 0);
        check_val("rst_idx", rf_reg_in, 0);
        check_val("rst_data", rf_data_in, 0);
        check_val("rst_busy", clear_busy, 1);

        // Clear sequence with A holding a read of reg 9 from release.
        preload = 1'b0;
        RESET = 1'b0;
        drv_a(1, 0, 9, 0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            check_val("clr_we", rf_write_ctrl, 1);
            check_val("clr_idx", rf_reg_in, i);
            check_val("clr_data", rf_data_in, 0);
            check_val("clr_busy", clear_busy, 1);
            check_val("clr_agnt", a_if.gnt, 0);
            tick();
        end
        #1;
        check_val("c16_busy", clear_busy, 0);
        check_val("c16_agnt", a_if.gnt, 1);
        check_val("c16_idx", rf_reg_in, 9);
        check_val("c16_we", rf_write_ctrl, 0);
        tick();
        drv_a(0, 0, 0, 0, 0);
        #1;
        check_val("rd9_rvalid", a_if.rvalid, 1);
        check_val("rd9_rdata", a_if.rdata, 8'h00);
        check_val("rd9_agnt", a_if.gnt, 0);
        tick();

        drv_a(1, 0, 15, 0, 0);
        #1;
        check_val("rd15_gnt", a_if.gnt, 1);
        tick();
        drv_a(0, 0, 0, 0, 0);
        #1;
        check_val("rd15_rvalid", a_if.rvalid, 1);
        check_val("rd15_rdata", a_if.rdata, 8'h00);
        tick();

        // Write then read back the same register.
        drv_a(1, 1, 3, 8'h5A, 0);
        #1;
        check_val("wr_gnt", a_if.gnt, 1);
        check_val("wr_we", rf_write_ctrl, 1);
        check_val("wr_idx", rf_reg_in, 3);
        check_val("wr_data", rf_data_in, 8'h5A);
        tick();
        drv_a(1, 0, 3, 0, 0);
        #1;
        check_val("rb_gnt", a_if.gnt, 1);
        check_val("rb_we", rf_write_ctrl, 0);
        check_val("wr_no_rvalid", a_if.rvalid, 0);
        tick();
        drv_a(0, 0, 0, 0, 0);
        #1;
        check_val("rb_rvalid", a_if.rvalid, 1);
        check_val("rb_rdata", a_if.rdata, 8'h5A);
        check_val("rb_brvalid", b_if.rvalid, 0);
        tick();
        #1;
        check_val("rb_pulse", a_if.rvalid, 0);
        check_val("rb_hold", a_if.rdata, 8'h5A);
        tick();

        // Reset, then a second reset in clear cycle 7.
        RESET = 1'b1;
        #1;
        check_val("r2_we", rf_write_ctrl, 0);
        check_val("r2_busy", clear_busy, 1);
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check_val("r2_idx", rf_reg_in, i);
            tick();
        end
        RESET = 1'b1;
        #1;
        check_val("mid_we", rf_write_ctrl, 0);
        check_val("mid_busy", clear_busy, 1);
        check_val("mid_idx", rf_reg_in, 0);
        tick();
        RESET = 1'b0;
        drv_a(1, 0, 3, 0, 0);
        drv_b(1, 0, 5, 0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            check_val("rs_idx", rf_reg_in, i);
            check_val("rs_agnt", a_if.gnt, 0);
            check_val("rs_bgnt", b_if.gnt, 0);
            tick();
        end

        // Continuous contention without locks alternates starting with A.
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val("rr_agnt", a_if.gnt, (k % 2 == 0));
            check_val("rr_bgnt", b_if.gnt, (k % 2 == 1));
            check_val("rr_arvalid", a_if.rvalid, (k % 2 == 1));
            check_val("rr_brvalid", b_if.rvalid, (k > 0 && k % 2 == 0));
            if (k == 1) check_val("rr_ardata", a_if.rdata, 8'h00);
            tick();
        end

        // A locks for three grants then releases: four A grants, then B.
        for (int k = 0; k < 5; k++) begin
            drv_a(1, 0, 3, 0, (k < 3));
            #1;
            check_val("lk_agnt", a_if.gnt, (k < 4));
            check_val("lk_bgnt", b_if.gnt, (k == 4));
            tick();
        end
        drv_b(0, 0, 0, 0, 0);
        drv_a(1, 0, 3, 0, 1);
        #1;
        check_val("lk_alone", a_if.gnt, 1);
        tick();
        drv_a(0, 0, 0, 0, 0);
        drv_b(1, 0, 5, 0, 0);
        #1;
        check_val("lone_b", b_if.gnt, 1);
        tick();

        // B writes and reads reg 7, then RESET lands on a B read grant.
        drv_b(1, 1, 7, 8'h33, 0);
        #1;
        check_val("bw_gnt", b_if.gnt, 1);
        check_val("bw_we", rf_write_ctrl, 1);
        tick();
        drv_b(1, 0, 7, 0, 0);
        #1;
        check_val("br_gnt", b_if.gnt, 1);
        tick();
        drv_b(0, 0, 0, 0, 0);
        #1;
        check_val("br_rvalid", b_if.rvalid, 1);
        check_val("br_rdata", b_if.rdata, 8'h33);
        tick();
        drv_b(1, 0, 7, 0, 0);
        RESET = 1'b1;
        #1;
        check_val("rg_bgnt", b_if.gnt, 0);
        check_val("rg_we", rf_write_ctrl, 0);
        check_val("rg_busy", clear_busy, 1);
        tick();
        RESET = 1'b0;
        drv_b(0, 0, 0, 0, 0);
        #1;
        check_val("rg_brvalid", b_if.rvalid, 0);
        check_val("rg_brdata", b_if.rdata, 0);
        check_val("rg_ardata", a_if.rdata, 0);
        check_val("rg_idx", rf_reg_in, 0);
        check_val("rg_clr_we", rf_write_ctrl, 1);
        tick();
        repeat (15) tick();
        #1;
        check_val("rg_busy_end", clear_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
